wb_io_arbiter: RTL and testbench
================================

Name: wb_io_arbiter

Overview:
- Two-master, one-slave Wishbone B4 classic arbiter in front of the rv32i_soc IO bus (UART, GPIO, SPI, SPI-flash slaves).
- Master 0 is the core's data port. Master 1 is a secondary requester (debug/bench/DMA master).
- Grants are round-robin and locked for the duration of the owner's CYC.
- Optional watchdog aborts transfers that receive no ACK.

Parameters:
AW, 32, address width
DW, 32, data width (SEL width = DW/8)
TIMEOUT_CYCLES, 255, stalled-cycle limit before abort (valid only with WB_ARB_TIMEOUT_EN; range 2..65535)

Ports:
clock  in  1  single system clock, all logic rising-edge
reset  in  1  synchronous active-low reset
m0_adr_i / m1_adr_i  in  AW  master address
m0_dat_i / m1_dat_i  in  DW  master write data
m0_sel_i / m1_sel_i  in  DW/8  byte selects
m0_we_i / m1_we_i  in  1  write enable
m0_cyc_i / m1_cyc_i  in  1  bus cycle request
m0_stb_i / m1_stb_i  in  1  strobe
m0_dat_o / m1_dat_o  out  DW  read data (broadcast of s_dat_i)
m0_ack_o / m1_ack_o  out  1  ack, owner only
m0_err_o / m1_err_o  out  1  timeout error, owner only
s_adr_o  out  AW  to IO slave
s_dat_o  out  DW  to IO slave
s_sel_o  out  DW/8  to IO slave
s_we_o  out  1  to IO slave
s_cyc_o  out  1  to IO slave
s_stb_o  out  1  to IO slave
s_dat_i  in  DW  from IO slave
s_ack_i  in  1  from IO slave
grant_o  out  2  one-hot current owner; 00 = none

Behaviour:
- Clock and reset: one clock (clock); reset is synchronous and active-low (reset). Reset applies at the next rising edge.
- Reset values:
  - state=IDLE, owner=none, rr_ptr=0 (m0 preferred), timeout counter=0.
  - All s_*_o=0, all mX_ack_o/mX_err_o=0, grant_o=00, mX_dat_o=s_dat_i.
- States: IDLE, BUSY, ABORT.
- IDLE:
  - A request is mX_cyc_i&mX_stb_i.
  - Single request: grant that master at the next edge.
  - Both requesting: grant master rr_ptr.
  - Go to BUSY. The slave sees nothing in the arbitration cycle, so arbitration latency is 1 cycle.
- BUSY:
  - s_* outputs are combinationally muxed from the owner.
  - s_cyc_o=owner cyc, s_stb_o=owner stb.
  - owner_ack_o=s_ack_i; the non-owner ack/err is always 0.
  - The grant holds while owner cyc=1, so back-to-back/burst strobes under one CYC never lose the bus.
  - Owner cyc=0 at an edge:
    - rr_ptr <= other master.
    - If the other master requests at that edge, grant it directly (BUSY->BUSY, handover with no IDLE cycle). Otherwise go to IDLE.
  - The slave sees cyc=0 for at least the cycle in which the old owner dropped it.
- A non-owner holding a request simply waits; it gets no ack/err.
- s_ack_i while state!=BUSY is ignored.
- Reset mid-transfer: the next edge forces IDLE. Slave cyc/stb drop that edge regardless of master inputs.
- grant_o reflects the registered owner.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Enabled:
  - The 16-bit counter increments each BUSY cycle with s_stb_o=1 and s_ack_i=0.
  - It clears on ack, on owner stb=0, and on leaving BUSY.
  - On reaching TIMEOUT_CYCLES: go to ABORT for exactly 1 cycle.
- ABORT:
  - owner_err_o=1, owner_ack_o=0, s_cyc_o=s_stb_o=0.
  - Then go to IDLE with rr_ptr flipped.
  - The aborted master must re-arbitrate.
- Disabled: no counter, mX_err_o tied 0, ABORT unreachable.

Test Plan:
- Reset low 3 cycles with m0 requesting -> all outputs 0, grant_o=00. After reset high: grant_o=01 after 1 cycle, s_adr_o=m0_adr_i.
- m0 write adr=0x2000_0000 dat=0xA5A5_A5A5 sel=F, slave acks after 2 cycles -> s_* match m0, m0_ack_o one cycle, m1_ack_o stays 0.
- m0 and m1 both request from IDLE after reset -> m0 granted first. m0 drops cyc while m1 still requesting -> grant_o goes to 10 at the next edge with no IDLE cycle. Next simultaneous request -> m0 wins (round robin).
- m0 holds cyc for 4 strobes while m1 requests -> m1 gets no grant until m0 cyc=0. All 4 acks go to m0 only; m1 never sees ack.
- WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks m1 read -> m1_err_o=1 exactly one cycle, 8 stalled cycles after the strobe. s_cyc_o=0 that cycle, then IDLE.
- Reset asserted mid-transfer while slave is stalled -> s_cyc_o=0 and grant_o=00 after the next edge. A late s_ack_i is ignored (no mX_ack_o).

Source files
------------

// File: rtl/wb_io_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wb_io_arbiter                                                |
// | Description : Two-master / one-slave Wishbone B4 classic arbiter for the   |
// |               rv32i_soc IO bus. Round-robin grant, locked for the whole    |
// |               CYC of the owner. Optional no-ACK watchdog that aborts the   |
// |               transfer with an error pulse (macro WB_ARB_TIMEOUT_EN).      |
// | Ports       : clock, reset (sync, active-low)                              |
// |               m0_* / m1_*  : master side (adr, dat, sel, we, cyc, stb in;  |
// |                              dat, ack, err out)                            |
// |               s_*          : slave side (adr, dat, sel, we, cyc, stb out;  |
// |                              dat, ack in)                                  |
// |               grant_o      : one-hot registered owner, 00 = none           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module wb_io_arbiter #(
   parameter int AW             = 32,
   parameter int DW             = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [AW-1:0]   m0_adr_i,
   input  logic [DW-1:0]   m0_dat_i,
   input  logic [DW/8-1:0] m0_sel_i,
   input  logic            m0_we_i,
   input  logic            m0_cyc_i,
   input  logic            m0_stb_i,
   output logic [DW-1:0]   m0_dat_o,
   output logic            m0_ack_o,
   output logic            m0_err_o,
   input  logic [AW-1:0]   m1_adr_i,
   input  logic [DW-1:0]   m1_dat_i,
   input  logic [DW/8-1:0] m1_sel_i,
   input  logic            m1_we_i,
   input  logic            m1_cyc_i,
   input  logic            m1_stb_i,
   output logic [DW-1:0]   m1_dat_o,
   output logic            m1_ack_o,
   output logic            m1_err_o,
   output logic [AW-1:0]   s_adr_o,
   output logic [DW-1:0]   s_dat_o,
   output logic [DW/8-1:0] s_sel_o,
   output logic            s_we_o,
   output logic            s_cyc_o,
   output logic            s_stb_o,
   input  logic [DW-1:0]   s_dat_i,
   input  logic            s_ack_i,
   output logic [1:0]      grant_o
);

   localparam logic [1:0] c_st_idle  = 2'd0;
   localparam logic [1:0] c_st_busy  = 2'd1;
   localparam logic [1:0] c_st_abort = 2'd2;

   logic [1:0] r_state;
   logic [1:0] w_state_nxt;
   logic [1:0] r_owner;        // one-hot: bit0 = m0, bit1 = m1
   logic [1:0] w_owner_nxt;
   logic       r_rr_ptr;       // 0 = m0 preferred on a tie, 1 = m1 preferred
   logic       w_rr_ptr_nxt;

   logic w_req0;
   logic w_req1;
   logic w_own_cyc;
   logic w_own_stb;
   logic w_other_req;
   logic w_tmo_hit;

   assign w_req0      = m0_cyc_i & m0_stb_i;
   assign w_req1      = m1_cyc_i & m1_stb_i;
   assign w_own_cyc   = (r_owner[0] & m0_cyc_i) | (r_owner[1] & m1_cyc_i);
   assign w_own_stb   = (r_owner[0] & m0_stb_i) | (r_owner[1] & m1_stb_i);
   assign w_other_req = (r_owner[0] & w_req1) | (r_owner[1] & w_req0);

   // Legal watchdog range is 2..65535; the counter and compare are 16 bits.
   generate
      if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range_bad
         // Out-of-range values truncate into the 16-bit compare; nothing to build.
      end
   endgenerate

`ifdef WB_ARB_TIMEOUT_EN
   localparam logic [15:0] c_tmo_last = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] r_tmo_cnt;
   logic        w_stall;

   // A stalled cycle: owner is strobing the slave and no ACK came back.
   assign w_stall   = (r_state == c_st_busy) & w_own_cyc & w_own_stb & ~s_ack_i;
   // The stall that would bring the count to TIMEOUT_CYCLES triggers the abort.
   assign w_tmo_hit = w_stall & (r_tmo_cnt == c_tmo_last);

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_tmo_cnt <= 16'd0;
      end else if (w_stall && !w_tmo_hit) begin
         r_tmo_cnt <= r_tmo_cnt + 16'd1;
      end else begin
         r_tmo_cnt <= 16'd0;
      end
   end
`else
   assign w_tmo_hit = 1'b0;
`endif

   // State register
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state  <= c_st_idle;
         r_owner  <= 2'b00;
         r_rr_ptr <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_owner  <= w_owner_nxt;
         r_rr_ptr <= w_rr_ptr_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt  = r_state;
      w_owner_nxt  = r_owner;
      w_rr_ptr_nxt = r_rr_ptr;
      case (r_state)
         c_st_idle: begin
            if (w_req0 | w_req1) begin
               w_state_nxt = c_st_busy;
               if (w_req0 && (!w_req1 || !r_rr_ptr)) begin
                  w_owner_nxt = 2'b01;
               end else begin
                  w_owner_nxt = 2'b10;
               end
            end
         end
         c_st_busy: begin
            if (!w_own_cyc) begin
               // Point at the other master; owner m0 -> ptr 1, owner m1 -> ptr 0.
               w_rr_ptr_nxt = r_owner[0];
               if (w_other_req) begin
                  // Direct handover, the slave already saw cyc=0 this cycle.
                  w_owner_nxt = ~r_owner;
               end else begin
                  w_state_nxt = c_st_idle;
                  w_owner_nxt = 2'b00;
               end
            end else if (w_tmo_hit) begin
               // Owner is kept for one cycle so the error reaches it.
               w_state_nxt = c_st_abort;
            end
         end
         c_st_abort: begin
            w_state_nxt  = c_st_idle;
            w_owner_nxt  = 2'b00;
            w_rr_ptr_nxt = r_owner[0];
         end
         default: begin
            w_state_nxt = c_st_idle;
            w_owner_nxt = 2'b00;
         end
      endcase
   end

   // Output logic
   always_comb begin
      s_adr_o  = '0;
      s_dat_o  = '0;
      s_sel_o  = '0;
      s_we_o   = 1'b0;
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      m0_ack_o = 1'b0;
      m1_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m1_err_o = 1'b0;
      if (r_state == c_st_busy) begin
         if (r_owner[1]) begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = m1_sel_i;
            s_we_o  = m1_we_i;
         end else begin
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_sel_o = m0_sel_i;
            s_we_o  = m0_we_i;
         end
         s_cyc_o  = w_own_cyc;
         s_stb_o  = w_own_stb;
         m0_ack_o = r_owner[0] & s_ack_i;
         m1_ack_o = r_owner[1] & s_ack_i;
      end
`ifdef WB_ARB_TIMEOUT_EN
      if (r_state == c_st_abort) begin
         m0_err_o = r_owner[0];
         m1_err_o = r_owner[1];
      end
`endif
   end

   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;
   assign grant_o  = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_wb_io_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_wb_io_arbiter                                             |
// | Description : Directed self-checking bench for wb_io_arbiter               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_wb_io_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
   logic [3:0]  m0_sel, m1_sel;
   logic        m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb;
   logic [31:0] s_dat_in;
   logic        s_ack;
   logic [31:0] m0_rdat, m1_rdat, s_adr, s_wdat;
   logic [3:0]  s_sel;
   logic        s_we, s_cyc, s_stb;
   logic        m0_ack, m1_ack, m0_err, m1_err;
   logic [1:0]  grant;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   wb_io_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYCLES(8)) dut (
      .clock(clk), .reset(rst_n),
      .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
      .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack),
      .m0_err_o(m0_err),
      .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
      .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack),
      .m1_err_o(m1_err),
      .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_sel_o(s_sel), .s_we_o(s_we),
      .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_dat_i(s_dat_in), .s_ack_i(s_ack),
      .grant_o(grant)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      m0_adr = '0; m0_dat = '0; m0_sel = '0; m0_we = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
      m1_adr = '0; m1_dat = '0; m1_sel = '0; m1_we = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
      s_ack = 1'b0;
   endtask

   task automatic do_reset();
      idle_all();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      idle_all();
      s_dat_in = 32'hDEAD_BEEF;
      rst_n = 1'b0;
      m0_adr = 32'h0000_1234; m0_cyc = 1'b1; m0_stb = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (grant !== 2'b00) begin failures++; $display("FAIL rst_grant actual=%b expected=00", grant); end
         checks++; if ({s_cyc, s_stb, s_we} !== 3'b000) begin failures++; $display("FAIL rst_s_ctrl actual=%b expected=000", {s_cyc, s_stb, s_we}); end
         checks++; if (s_adr !== 32'h0) begin failures++; $display("FAIL rst_s_adr actual=%h expected=0", s_adr); end
         checks++; if ({m0_ack, m1_ack, m0_err, m1_err} !== 4'b0000) begin failures++; $display("FAIL rst_ack_err actual=%b expected=0000", {m0_ack, m1_ack, m0_err, m1_err}); end
      end
      checks++; if (m1_rdat !== 32'hDEAD_BEEF || m0_rdat !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rst_dat_bcast actual=%h/%h expected=deadbeef", m0_rdat, m1_rdat); end
      rst_n = 1'b1;
      tick();
      checks++; if (grant !== 2'b01) begin failures++; $display("FAIL rst_first_grant actual=%b expected=01", grant); end
      checks++; if (s_adr !== 32'h0000_1234) begin failures++; $display("FAIL rst_first_adr actual=%h expected=00001234", s_adr); end
      checks++; if (s_cyc !== 1'b1) begin failures++; $display("FAIL rst_first_cyc actual=%b expected=1", s_cyc); end
      m0_cyc = 1'b0; m0_stb = 1'b0;
      tick();
      tick();
      checks++; if (grant !== 2'b00) begin failures++; $display("FAIL rst_release actual=%b expected=00", grant); end
   endtask

   task automatic test_write();
      do_reset();
      m0_adr = 32'h2000_0000; m0_dat = 32'hA5A5_A5A5; m0_sel = 4'hF; m0_we = 1'b1;
      m0_cyc = 1'b1; m0_stb = 1'b1;
      tick();
      checks++; if (grant !== 2'b01) begin failures++; $display("FAIL wr_grant actual=%b expected=01", grant); end
      checks++; if ({s_adr, s_wdat} !== {32'h2000_0000, 32'hA5A5_A5A5}) begin failures++; $display("FAIL wr_s_adr_dat actual=%h/%h expected=20000000/a5a5a5a5", s_adr, s_wdat); end
      checks++; if ({s_sel, s_we, s_cyc, s_stb} !== 7'b1111_111) begin failures++; $display("FAIL wr_s_ctrl actual=%b expected=1111111", {s_sel, s_we, s_cyc, s_stb}); end
      checks++; if (m0_ack !== 1'b0) begin failures++; $display("FAIL wr_early_ack actual=%b expected=0", m0_ack); end
      tick();
      checks++; if (m0_ack !== 1'b0) begin failures++; $display("FAIL wr_wait_ack actual=%b expected=0", m0_ack); end
      s_ack = 1'b1;
      #1;
      checks++; if ({m0_ack, m1_ack} !== 2'b10) begin failures++; $display("FAIL wr_ack actual=%b expected=10", {m0_ack, m1_ack}); end
      tick();
      s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
      #1;
      checks++; if ({m0_ack, m1_ack, s_cyc} !== 3'b000) begin failures++; $display("FAIL wr_after_ack actual=%b expected=000", {m0_ack, m1_ack, s_cyc}); end
      tick();
      checks++; if (grant !== 2'b00) begin failures++; $display("FAIL wr_idle actual=%b expected=00", grant); end
   endtask

   task automatic test_round_robin();
      do_reset();
      m0_adr = 32'h0000_00A0; m0_cyc = 1'b1; m0_stb = 1'b1;
      m1_adr = 32'h0000_00B0; m1_cyc = 1'b1; m1_stb = 1'b1;
      tick();
      checks++; if (grant !== 2'b01 || s_adr !== 32'hA0) begin failures++; $display("FAIL rr_first actual=%b/%h expected=01/a0", grant, s_adr); end
      s_ack = 1'b1;
      #1;
      checks++; if ({m0_ack, m1_ack} !== 2'b10) begin failures++; $display("FAIL rr_ack_m0 actual=%b expected=10", {m0_ack, m1_ack}); end
      tick();
      s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
      #1;
      checks++; if (s_cyc !== 1'b0 || grant !== 2'b01) begin failures++; $display("FAIL rr_drop_cycle actual=%b/%b expected=0/01", s_cyc, grant); end
      tick();
      checks++; if (grant !== 2'b10 || s_adr !== 32'hB0 || s_cyc !== 1'b1) begin failures++; $display("FAIL rr_handover actual=%b/%h/%b expected=10/b0/1", grant, s_adr, s_cyc); end
      s_ack = 1'b1;
      #1;
      checks++; if ({m0_ack, m1_ack} !== 2'b01) begin failures++; $display("FAIL rr_ack_m1 actual=%b expected=01", {m0_ack, m1_ack}); end
      tick();
      s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
      tick();
      checks++; if (grant !== 2'b00) begin failures++; $display("FAIL rr_idle1 actual=%b expected=00", grant); end
      m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
      tick();
      checks++; if (grant !== 2'b01) begin failures++; $display("FAIL rr_second_m0 actual=%b expected=01", grant); end
      s_ack = 1'b1;
      tick();
      s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
      tick();
      checks++; if (grant !== 2'b00) begin failures++; $display("FAIL rr_idle2 actual=%b expected=00", grant); end
      m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
      tick();
      checks++; if (grant !== 2'b10 || s_adr !== 32'hB0) begin failures++; $display("FAIL rr_third_m1 actual=%b/%h expected=10/b0", grant, s_adr); end
      idle_all();
      tick();
      tick();
   endtask

   task automatic test_back_to_back();
      int m0_acks;
      m0_acks = 0;
      do_reset();
      m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0000_0100;
      tick();
      m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h0000_0200;
      for (int i = 0; i < 4; i++) begin
         m0_adr = 32'h0000_0100 + 32'(4 * i);
         s_ack = 1'b1;
         #1;
         checks++; if (grant !== 2'b01 || s_adr !== 32'h0000_0100 + 32'(4 * i)) begin failures++; $display("FAIL b2b_owner_%0d actual=%b/%h expected=01/%h", i, grant, s_adr, 32'h0000_0100 + 32'(4 * i)); end
         checks++; if (m1_ack !== 1'b0) begin failures++; $display("FAIL b2b_m1_ack_%0d actual=%b expected=0", i, m1_ack); end
         if (m0_ack === 1'b1) m0_acks++;
         tick();
      end
      checks++; if (m0_acks !== 4) begin failures++; $display("FAIL b2b_m0_acks actual=%0d expected=4", m0_acks); end
      s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
      tick();
      checks++; if (grant !== 2'b10 || s_adr !== 32'h0000_0200) begin failures++; $display("FAIL b2b_handover actual=%b/%h expected=10/00000200", grant, s_adr); end
      idle_all();
      tick();
      tick();
   endtask

   task automatic test_timeout();
      do_reset();
      m1_adr = 32'h3000_0004; m1_we = 1'b0; m1_cyc = 1'b1; m1_stb = 1'b1;
      tick();
      checks++; if (grant !== 2'b10) begin failures++; $display("FAIL tmo_grant actual=%b expected=10", grant); end
`ifdef WB_ARB_TIMEOUT_EN
      for (int k = 1; k <= 8; k++) begin
         checks++; if (m1_err !== 1'b0 || s_cyc !== 1'b1) begin failures++; $display("FAIL tmo_stall_%0d actual=%b/%b expected=0/1", k, m1_err, s_cyc); end
         tick();
      end
      checks++; if (m1_err !== 1'b1 || m0_err !== 1'b0) begin failures++; $display("FAIL tmo_err actual=%b/%b expected=1/0", m1_err, m0_err); end
      checks++; if ({s_cyc, s_stb, m1_ack} !== 3'b000) begin failures++; $display("FAIL tmo_abort_bus actual=%b expected=000", {s_cyc, s_stb, m1_ack}); end
      tick();
      checks++; if (m1_err !== 1'b0 || grant !== 2'b00) begin failures++; $display("FAIL tmo_after actual=%b/%b expected=0/00", m1_err, grant); end
`else
      for (int k = 1; k <= 12; k++) begin
         checks++; if (m1_err !== 1'b0 || s_cyc !== 1'b1 || grant !== 2'b10) begin failures++; $display("FAIL notmo_stall_%0d actual=%b/%b/%b expected=0/1/10", k, m1_err, s_cyc, grant); end
         tick();
      end
`endif
      idle_all();
      tick();
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      m0_adr = 32'h4000_0000; m0_we = 1'b1; m0_cyc = 1'b1; m0_stb = 1'b1;
      tick();
      tick();
      checks++; if (s_cyc !== 1'b1 || grant !== 2'b01) begin failures++; $display("FAIL mid_busy actual=%b/%b expected=1/01", s_cyc, grant); end
      rst_n = 1'b0;
      tick();
      checks++; if ({s_cyc, s_stb} !== 2'b00 || grant !== 2'b00) begin failures++; $display("FAIL mid_reset actual=%b/%b expected=00/00", {s_cyc, s_stb}, grant); end
      s_ack = 1'b1;
      #1;
      checks++; if ({m0_ack, m1_ack} !== 2'b00) begin failures++; $display("FAIL mid_late_ack actual=%b expected=00", {m0_ack, m1_ack}); end
      idle_all();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_write();
      test_round_robin();
      test_back_to_back();
      test_timeout();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
